// File: rtl/tpe_lane_seq_if.sv
// Command, completion and operand-read bundle of the TPE lane sequencer.
// The sequencer uses the slave modport; the fabric/memory side uses master.
interface tpe_lane_seq_if #(
    parameter int LANES  = 8,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_w_base;
    logic [ADDR_W-1:0] cmd_x_base;
    logic [LEN_W-1:0]  cmd_len;
    logic [31:0]       cmd_hints;

    logic                 mem_rd_en;
    logic [ADDR_W-1:0]    mem_w_addr;
    logic [ADDR_W-1:0]    mem_x_addr;
    logic [2*LANES-1:0]   mem_w_data;
    logic [2*LANES-1:0]   mem_x_data;

    logic        done_valid;
    logic        done_ready;
    logic [31:0] done_cycles;

    modport master (
        output cmd_valid, cmd_w_base, cmd_x_base, cmd_len, cmd_hints,
        input  cmd_ready,
        input  mem_rd_en, mem_w_addr, mem_x_addr,
        output mem_w_data, mem_x_data,
        input  done_valid, done_cycles,
        output done_ready
    );

    modport slave (
        input  cmd_valid, cmd_w_base, cmd_x_base, cmd_len, cmd_hints,
        output cmd_ready,
        output mem_rd_en, mem_w_addr, mem_x_addr,
        input  mem_w_data, mem_x_data,
        output done_valid, done_cycles,
        input  done_ready
    );
endinterface

// File: rtl/tpe_lane_sequencer.sv
// Job sequencer for a row of ternary lane ALUs: clear, stream operands, drain, report.
// Optional zero-operand lane-step counter is built when TPE_SEQ_SKIP_COUNT_EN is defined.

// One lane's operand register; the unused trit code 2'b11 is sanitised to zero.
module tpe_lane_slot (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [1:0] w_in,
    input  logic [1:0] x_in,
    output logic [1:0] w_q,
    output logic [1:0] x_q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q <= 2'b00;
            x_q <= 2'b00;
        end else if (load) begin
            w_q <= (w_in == 2'b11) ? 2'b00 : w_in;
            x_q <= (x_in == 2'b11) ? 2'b00 : x_in;
        end
    end
endmodule

module tpe_lane_sequencer #(
    parameter int LANES  = 8,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    tpe_lane_seq_if.slave      bus,
    input  logic               pause,
    output logic [2*LANES-1:0] lane_weight,
    output logic [2*LANES-1:0] lane_trit,
    output logic [31:0]        lane_hints,
    output logic               lane_enable,
    output logic               lane_clear,
    output logic               busy,
    output logic [31:0]        skip_count
);
    localparam int STAGES = 2;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] w_ptr, x_ptr;
    logic [LEN_W-1:0]  rem;
    logic [STAGES:0]   vld_pipe;
    logic [31:0]       cyc_q;
    logic              done_q;
    logic              accept, issue, ack;

    logic [LANES-1:0][1:0] w_lane, x_lane;

    assign accept      = bus.cmd_valid && (state == S_IDLE);
    assign issue       = (state == S_STREAM) && !pause;
    assign ack         = done_q && bus.done_ready;
    assign vld_pipe[0] = issue;

    assign bus.cmd_ready   = (state == S_IDLE);
    assign bus.mem_rd_en   = issue;
    assign bus.mem_w_addr  = w_ptr;
    assign bus.mem_x_addr  = x_ptr;
    assign bus.done_valid  = done_q;
    assign bus.done_cycles = cyc_q;

    assign lane_clear  = (state == S_CLEAR);
    assign busy        = (state != S_IDLE);
    assign lane_enable = vld_pipe[STAGES];
    assign lane_weight = w_lane;
    assign lane_trit   = x_lane;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept) state_nx = S_CLEAR;
            S_CLEAR:  state_nx = (rem != '0) ? S_STREAM : S_DONE;
            S_STREAM: if (issue && rem == LEN_W'(1)) state_nx = S_DRAIN;
            // Last issue was two cycles back once stage 1 is empty: its enable is now.
            S_DRAIN:  if (!vld_pipe[1]) state_nx = S_DONE;
            S_DONE:   if (ack) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr              <= '0;
            x_ptr              <= '0;
            rem                <= '0;
            lane_hints         <= '0;
            vld_pipe[STAGES:1] <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (accept) begin
                w_ptr      <= bus.cmd_w_base;
                x_ptr      <= bus.cmd_x_base;
                rem        <= bus.cmd_len;
                lane_hints <= bus.cmd_hints;
            end else if (issue) begin
                w_ptr <= w_ptr + ADDR_W'(1);
                x_ptr <= x_ptr + ADDR_W'(1);
                rem   <= rem - LEN_W'(1);
            end
        end
    end

    // done_valid is registered one cycle into DONE; cyc_q freezes on its rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
            cyc_q  <= '0;
        end else begin
            if (ack)                  done_q <= 1'b0;
            else if (state == S_DONE) done_q <= 1'b1;

            if (accept)
                cyc_q <= '0;
            else if (busy && !done_q && cyc_q != 32'hFFFF_FFFF)
                cyc_q <= cyc_q + 32'd1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        tpe_lane_slot u_slot (
            .clk   (clk),
            .reset (reset),
            .load  (vld_pipe[1]),
            .w_in  (bus.mem_w_data[2*i +: 2]),
            .x_in  (bus.mem_x_data[2*i +: 2]),
            .w_q   (w_lane[i]),
            .x_q   (x_lane[i])
        );
    end

`ifdef TPE_SEQ_SKIP_COUNT_EN
    localparam int CW = $clog2(LANES + 1);
    logic [CW-1:0] zero_n;
    logic [32:0]   skip_sum;

    always_comb begin
        zero_n = '0;
        for (int i = 0; i < LANES; i++)
            if (w_lane[i] == 2'b00 || x_lane[i] == 2'b00) zero_n = zero_n + CW'(1);
        skip_sum = {1'b0, skip_count} + 33'(zero_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            skip_count <= '0;
        else if (accept)      skip_count <= '0;
        else if (lane_enable) skip_count <= skip_sum[32] ? 32'hFFFF_FFFF : skip_sum[31:0];
    end
`else
    assign skip_count = '0;
`endif
endmodule

// File: tb/tb_tpe_lane_sequencer.sv
// Directed bench for tpe_lane_sequencer with a one-cycle-latency operand memory model.
module tb_tpe_lane_sequencer;
    localparam int LANES = 8, ADDR_W = 10, LEN_W = 16;
`ifdef TPE_SEQ_SKIP_COUNT_EN
    localparam logic [31:0] SKIP_EXP = 32'd12;
`else
    localparam logic [31:0] SKIP_EXP = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pause = 1'b0;
    logic [15:0] lane_weight, lane_trit;
    logic [31:0] lane_hints, skip_count;
    logic        lane_enable, lane_clear, busy;

    tpe_lane_seq_if #(.LANES(LANES), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    tpe_lane_sequencer #(.LANES(LANES), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .bus(bus), .pause(pause),
        .lane_weight(lane_weight), .lane_trit(lane_trit), .lane_hints(lane_hints),
        .lane_enable(lane_enable), .lane_clear(lane_clear), .busy(busy),
        .skip_count(skip_count)
    );

    always #5 clk = ~clk;

    logic [15:0] wmem [0:1023];
    logic [15:0] xmem [0:1023];
    logic [15:0] mw = '0, mx = '0;
    always @(posedge clk) if (bus.mem_rd_en) begin
        mw <= wmem[bus.mem_w_addr];
        mx <= xmem[bus.mem_x_addr];
    end
    assign bus.mem_w_data = mw;
    assign bus.mem_x_data = mx;

    int neg_n = 0, rd_n = 0, en_n = 0, clr_n = 0, clr_t = 0;
    logic [9:0] wq[$];
    int rt[$];
    always @(negedge clk) begin
        neg_n <= neg_n + 1;
        if (bus.mem_rd_en) begin
            rd_n <= rd_n + 1;
            wq.push_back(bus.mem_w_addr);
            rt.push_back(neg_n);
        end
        if (lane_enable) en_n <= en_n + 1;
        if (lane_clear) begin
            clr_n <= clr_n + 1;
            clr_t <= neg_n;
        end
    end

    int errors = 0, checks = 0;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic fill(input logic [9:0] wb, input logic [9:0] xb, input int n,
                        input logic [15:0] wv, input logic [15:0] xv);
        for (int i = 0; i < n; i++) begin
            wmem[wb + 10'(i)] = wv;
            xmem[xb + 10'(i)] = xv;
        end
    endtask

    task automatic start_job(input logic [9:0] wb, input logic [9:0] xb,
                             input logic [15:0] len, input logic [31:0] hints, output int acc);
        tick();
        bus.cmd_w_base = wb; bus.cmd_x_base = xb;
        bus.cmd_len = len;   bus.cmd_hints = hints;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        acc = neg_n;
    endtask

    task automatic wait_done(input int acc, output int lat);
        int g = 0;
        @(negedge clk);
        while (!bus.done_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
        lat = neg_n - acc;
        checks++;
        if (bus.done_valid !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: done_valid=%b required 1", bus.done_valid);
        end
    endtask

    task automatic ack_done();
        tick();
        bus.done_ready = 1'b1;
        @(posedge clk); #1;
        bus.done_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_ctl: cmd_ready=%b busy=%b required 1/0", bus.cmd_ready, busy);
        end
        checks++;
        if ({bus.mem_rd_en, lane_enable, lane_clear, bus.done_valid} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes: rd/en/clr/done=%b required 0000",
                {bus.mem_rd_en, lane_enable, lane_clear, bus.done_valid});
        end
        checks++;
        if (lane_weight !== 16'h0 || lane_trit !== 16'h0 || lane_hints !== 32'h0 ||
            bus.done_cycles !== 32'h0 || skip_count !== 32'h0) begin
            errors++; $display("FAIL reset_data: w=%h x=%h hints=%h cyc=%h skip=%h required all 0",
                lane_weight, lane_trit, lane_hints, bus.done_cycles, skip_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int acc, lat, r0, e0, c0, q0;
        fill(10'h020, 10'h100, 4, 16'h5555, 16'hAAAA);
        r0 = rd_n; e0 = en_n; c0 = clr_n; q0 = wq.size();
        start_job(10'h020, 10'h100, 16'd4, 32'h1, acc);
        wait_done(acc, lat);
        checks++;
        if (en_n - e0 !== 4) begin errors++; $display("FAIL basic_enables: got %0d required 4", en_n - e0); end
        checks++;
        if (rd_n - r0 !== 4) begin errors++; $display("FAIL basic_reads: got %0d required 4", rd_n - r0); end
        checks++;
        if (clr_n - c0 !== 1 || rt[q0] - clr_t !== 1) begin
            errors++; $display("FAIL basic_clear: pulses=%0d gap=%0d required 1/1", clr_n - c0, rt[q0] - clr_t);
        end
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d required 8", lat); end
        checks++;
        if (bus.done_cycles !== 32'd8) begin errors++; $display("FAIL basic_cycles: got %0d required 8", bus.done_cycles); end
        checks++;
        if (lane_weight !== 16'h5555 || lane_trit !== 16'hAAAA || lane_hints !== 32'h1) begin
            errors++; $display("FAIL basic_data: w=%h x=%h hints=%h required 5555/aaaa/1", lane_weight, lane_trit, lane_hints);
        end
        ack_done();
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.done_valid !== 1'b0) begin
            errors++; $display("FAIL basic_return: cmd_ready=%b done_valid=%b required 1/0", bus.cmd_ready, bus.done_valid);
        end
    endtask

    task automatic test_len_zero();
        int acc, lat, r0, c0, bad;
        r0 = rd_n; c0 = clr_n; bad = 0;
        start_job(10'h000, 10'h000, 16'd0, 32'h2, acc);
        wait_done(acc, lat);
        checks++;
        if (lat !== 2 || bus.done_cycles !== 32'd2) begin
            errors++; $display("FAIL zero_latency: lat=%0d cyc=%0d required 2/2", lat, bus.done_cycles);
        end
        bus.cmd_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.done_valid !== 1'b1 || bus.cmd_ready !== 1'b0) bad++;
        end
        bus.cmd_valid = 1'b0;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL zero_hold: %0d bad cycles required 0", bad); end
        checks++;
        if (rd_n - r0 !== 0 || clr_n - c0 !== 1) begin
            errors++; $display("FAIL zero_strobes: reads=%0d clears=%0d required 0/1", rd_n - r0, clr_n - c0);
        end
        ack_done();
    endtask

    task automatic test_pause();
        int acc, lat, r0, e0, q0, bad;
        fill(10'h040, 10'h140, 6, 16'h5555, 16'h5555);
        r0 = rd_n; e0 = en_n; q0 = wq.size(); bad = 0;
        start_job(10'h040, 10'h140, 16'd6, 32'h3, acc);
        tick();
        tick(); pause = 1'b1;
        tick(); pause = 1'b0;
        tick(); pause = 1'b1;
        tick(); pause = 1'b0;
        wait_done(acc, lat);
        checks++;
        if (rd_n - r0 !== 6 || en_n - e0 !== 6) begin
            errors++; $display("FAIL pause_counts: reads=%0d enables=%0d required 6/6", rd_n - r0, en_n - e0);
        end
        for (int i = 0; i < 6; i++) if (wq[q0 + i] !== 10'h040 + 10'(i)) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL pause_addr: %0d wrong addresses required 0", bad); end
        checks++;
        if (rt[q0 + 1] - rt[q0] !== 2) begin
            errors++; $display("FAIL pause_gap: got %0d required 2", rt[q0 + 1] - rt[q0]);
        end
        checks++;
        if (lat !== 12 || bus.done_cycles !== 32'd12) begin
            errors++; $display("FAIL pause_cycles: lat=%0d cyc=%0d required 12/12", lat, bus.done_cycles);
        end
        ack_done();
    endtask

    task automatic test_wrap();
        int acc, lat, q0, bad;
        logic [9:0] exp_a [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        fill(10'h3FE, 10'h200, 4, 16'h5555, 16'hAAAA);
        q0 = wq.size(); bad = 0;
        start_job(10'h3FE, 10'h200, 16'd4, 32'h4, acc);
        wait_done(acc, lat);
        for (int i = 0; i < 4; i++) if (wq[q0 + i] !== exp_a[i]) bad++;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL wrap_addr: %0d wrong, first got %h required 3fe", bad, wq[q0]);
        end
        checks++;
        if (bus.done_cycles !== 32'd8) begin errors++; $display("FAIL wrap_cycles: got %0d required 8", bus.done_cycles); end
        ack_done();
    endtask

    task automatic test_sanitize();
        int acc, lat;
        fill(10'h060, 10'h160, 2, 16'hFF55, 16'h55D5);
        start_job(10'h060, 10'h160, 16'd2, 32'h5, acc);
        wait_done(acc, lat);
        checks++;
        if (lane_trit !== 16'h5515) begin errors++; $display("FAIL sanitize_trit: got %h required 5515", lane_trit); end
        checks++;
        if (lane_weight !== 16'h0055) begin errors++; $display("FAIL sanitize_weight: got %h required 0055", lane_weight); end
        ack_done();
    endtask

    task automatic test_skip_count();
        int acc, lat, e0;
        fill(10'h070, 10'h170, 3, 16'h0055, 16'h5555);
        e0 = en_n;
        start_job(10'h070, 10'h170, 16'd3, 32'h20000, acc);
        wait_done(acc, lat);
        checks++;
        if (en_n - e0 !== 3) begin errors++; $display("FAIL skip_enables: got %0d required 3", en_n - e0); end
        checks++;
        if (skip_count !== SKIP_EXP) begin errors++; $display("FAIL skip_count: got %0d required %0d", skip_count, SKIP_EXP); end
        ack_done();
    endtask

    task automatic test_reset_mid();
        int acc, lat, r0, e0, bad;
        fill(10'h080, 10'h180, 8, 16'h5555, 16'hAAAA);
        r0 = rd_n; bad = 0;
        start_job(10'h080, 10'h180, 16'd8, 32'h6, acc);
        tick(); tick(); tick();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 ||
            {bus.mem_rd_en, lane_enable, lane_clear, bus.done_valid} !== 4'b0000) begin
            errors++; $display("FAIL midreset_ctl: ready=%b busy=%b rd/en/clr/done=%b required 1/0/0000",
                bus.cmd_ready, busy, {bus.mem_rd_en, lane_enable, lane_clear, bus.done_valid});
        end
        checks++;
        if (lane_weight !== 16'h0 || lane_trit !== 16'h0 || lane_hints !== 32'h0) begin
            errors++; $display("FAIL midreset_data: w=%h x=%h hints=%h required 0", lane_weight, lane_trit, lane_hints);
        end
        checks++;
        if (rd_n - r0 !== 2) begin errors++; $display("FAIL midreset_reads: got %0d required 2", rd_n - r0); end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL midreset_nodone: %0d bad cycles required 0", bad); end
        e0 = en_n;
        start_job(10'h080, 10'h180, 16'd2, 32'h7, acc);
        wait_done(acc, lat);
        checks++;
        if (lat !== 6 || bus.done_cycles !== 32'd6 || en_n - e0 !== 2) begin
            errors++; $display("FAIL midreset_rerun: lat=%0d cyc=%0d en=%0d required 6/6/2",
                lat, bus.done_cycles, en_n - e0);
        end
        ack_done();
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_w_base = '0; bus.cmd_x_base = '0;
        bus.cmd_len = '0; bus.cmd_hints = '0; bus.done_ready = 1'b0;
        test_reset();
        test_basic();
        test_len_zero();
        test_pause();
        test_wrap();
        test_sanitize();
        test_skip_count();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
